framebuffer_swap_controller: RTL and testbench

Parametrised double-buffered successor to the single framebuffer in the GPU top level. Holds two pixel banks: the instruction engine writes the back bank while VGA output reads the front bank. Swaps are requested by the engine and committed only at vertical blank, so frames never tear. An optional hardware clear fills the new back bank after each swap.

---
 rtl/gpu_pkg.sv | 17 +
 rtl/fb_bank.sv | 36 +++
 rtl/framebuffer_swap_controller.sv | 186 ++++++++++++++++++
 tb/tb_framebuffer_swap_controller.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared GPU constants and types.
//   - Default pixel width and display resolution for the framebuffer.
//   - swap_state_t: state encoding of the double-buffer swap controller.
package gpu_pkg;

   localparam int DEFAULT_BITS_PER_PIXEL    = 3;
   localparam int DEFAULT_RESOLUTION_W      = 640;
   localparam int DEFAULT_RESOLUTION_H      = 480;
   localparam int DEFAULT_FRAMEBUFFER_DEPTH = DEFAULT_RESOLUTION_W * DEFAULT_RESOLUTION_H;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PENDING  = 2'd1,
      CLEARING = 2'd2
   } swap_state_t;

endpackage

// File: rtl/fb_bank.sv
// fb_bank: one framebuffer pixel bank.
// Simple dual-port synchronous RAM with one write port and one registered
// read port. There is no reset on the array or the read register, so the
// structure maps onto block RAM.
//   clk_i      clock
//   we_i       write strobe (caller guarantees waddr_i is in range)
//   waddr_i    write address
//   wdata_i    write pixel
//   raddr_i    read address
//   rdata_o    pixel at raddr_i, one cycle later
module fb_bank #(
   parameter int BITS_PER_PIXEL    = 3,
   parameter int FRAMEBUFFER_DEPTH = 16,
   parameter int ADDR_WIDTH        = 4
) (
   input  logic                      clk_i,
   input  logic                      we_i,
   input  logic [ADDR_WIDTH-1:0]     waddr_i,
   input  logic [BITS_PER_PIXEL-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0]     raddr_i,
   output logic [BITS_PER_PIXEL-1:0] rdata_o
);

   logic [BITS_PER_PIXEL-1:0] mem_q [FRAMEBUFFER_DEPTH];
   logic [BITS_PER_PIXEL-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/framebuffer_swap_controller.sv
// framebuffer_swap_controller: double-buffered framebuffer with tear-free swap.
// The instruction engine writes the back bank while VGA reads the front bank.
// A requested swap is committed only on a vertical-blank pulse; optionally
// the new back bank is then filled with a clear colour, one pixel per cycle.
//   i_Clock / i_Reset_N            clock, asynchronous active-low reset
//   i_Write_Enable/_Addr/_Data     engine write into the back bank
//   o_Write_Ready                  low while a hardware clear owns the back bank
//   i_Read_Addr / o_Read_Data      front-bank read, 1-cycle latency, 0 if out of range
//   i_Vblank_Start                 vblank pulse, the only point a swap may commit
//   i_Swap_Request                 swap request pulse
//   i_Clear_On_Swap/i_Clear_Color  clear enable and colour, sampled at commit
//   o_Front_Bank                   bank currently displayed
//   o_Swap_Pending                 a swap is waiting for vblank
//   o_Clear_Busy                   hardware clear in progress
//   o_Swap_Done                    pulse in the cycle after a commit
module framebuffer_swap_controller #(
   parameter int BITS_PER_PIXEL    = gpu_pkg::DEFAULT_BITS_PER_PIXEL,
   parameter int RESOLUTION_W      = gpu_pkg::DEFAULT_RESOLUTION_W,
   parameter int RESOLUTION_H      = gpu_pkg::DEFAULT_RESOLUTION_H,
   parameter int FRAMEBUFFER_DEPTH = RESOLUTION_W * RESOLUTION_H,
   parameter int ADDR_WIDTH        = $clog2(FRAMEBUFFER_DEPTH)
) (
   input  logic                      i_Clock,
   input  logic                      i_Reset_N,
   input  logic                      i_Write_Enable,
   input  logic [ADDR_WIDTH-1:0]     i_Write_Addr,
   input  logic [BITS_PER_PIXEL-1:0] i_Write_Data,
   output logic                      o_Write_Ready,
   input  logic [ADDR_WIDTH-1:0]     i_Read_Addr,
   output logic [BITS_PER_PIXEL-1:0] o_Read_Data,
   input  logic                      i_Vblank_Start,
   input  logic                      i_Swap_Request,
   input  logic                      i_Clear_On_Swap,
   input  logic [BITS_PER_PIXEL-1:0] i_Clear_Color,
   output logic                      o_Front_Bank,
   output logic                      o_Swap_Pending,
   output logic                      o_Clear_Busy,
   output logic                      o_Swap_Done
);

   import gpu_pkg::*;

   // Bank address width is set by the depth alone; the port width may be
   // wider so that out-of-range addresses can be presented and rejected.
   localparam int BANK_AW = (FRAMEBUFFER_DEPTH > 1) ? $clog2(FRAMEBUFFER_DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(FRAMEBUFFER_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] CNT_LAST  = ADDR_WIDTH'(FRAMEBUFFER_DEPTH - 1);

   swap_state_t               state_q, state_d;
   logic                      front_q, front_d;
   logic [ADDR_WIDTH-1:0]     cnt_q, cnt_d;
   logic [BITS_PER_PIXEL-1:0] clr_color_q, clr_color_d;
   logic                      req_q, req_d;
   logic                      done_q, done_d;
   logic                      rd_valid_q, rd_valid_d;
   logic                      rd_bank_q, rd_bank_d;

   logic                      clearing;
   logic                      wr_in_range;
   logic                      wr_en;
   logic [ADDR_WIDTH-1:0]     wr_addr;
   logic [BITS_PER_PIXEL-1:0] wr_data;
   logic                      we0, we1;
   logic [BANK_AW-1:0]        bank_waddr;
   logic [BANK_AW-1:0]        bank_raddr;
   logic [BITS_PER_PIXEL-1:0] rdata0, rdata1;

   // ---------------- state registers ----------------
   always_ff @(posedge i_Clock or negedge i_Reset_N) begin
      if (!i_Reset_N) begin
         state_q     <= IDLE;
         front_q     <= 1'b0;
         cnt_q       <= '0;
         clr_color_q <= '0;
         req_q       <= 1'b0;
         done_q      <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_bank_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         front_q     <= front_d;
         cnt_q       <= cnt_d;
         clr_color_q <= clr_color_d;
         req_q       <= req_d;
         done_q      <= done_d;
         rd_valid_q  <= rd_valid_d;
         rd_bank_q   <= rd_bank_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d     = state_q;
      front_d     = front_q;
      cnt_d       = cnt_q;
      clr_color_d = clr_color_q;
      req_d       = req_q;
      done_d      = 1'b0;
      // Read qualifiers are captured with the address so the output mux
      // uses the bank select of the address cycle.
      rd_valid_d  = ({1'b0, i_Read_Addr} < DEPTH_EXT);
      rd_bank_d   = front_q;

      unique case (state_q)
         IDLE: begin
            // A vblank in the same cycle as the request is too early.
            if (i_Swap_Request) begin
               state_d = PENDING;
            end
         end
         PENDING: begin
            if (i_Vblank_Start) begin
               front_d     = ~front_q;
               done_d      = 1'b1;
               clr_color_d = i_Clear_Color;
               state_d     = i_Clear_On_Swap ? CLEARING : IDLE;
            end
         end
         CLEARING: begin
            if (i_Swap_Request) begin
               req_d = 1'b1;
            end
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               req_d   = 1'b0;
               state_d = (req_q || i_Swap_Request) ? PENDING : IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------- write mux (engine vs clear) ----------------
   assign clearing    = (state_q == CLEARING);
   assign wr_in_range = ({1'b0, i_Write_Addr} < DEPTH_EXT);
   assign wr_en       = clearing || (i_Write_Enable && wr_in_range);
   assign wr_addr     = clearing ? cnt_q : i_Write_Addr;
   assign wr_data     = clearing ? clr_color_q : i_Write_Data;
   assign bank_waddr  = BANK_AW'(wr_addr);
   assign bank_raddr  = BANK_AW'(i_Read_Addr);

   // The back bank is always the one not being displayed.
   assign we0 = wr_en &&  front_q;
   assign we1 = wr_en && !front_q;

   fb_bank #(
      .BITS_PER_PIXEL    (BITS_PER_PIXEL),
      .FRAMEBUFFER_DEPTH (FRAMEBUFFER_DEPTH),
      .ADDR_WIDTH        (BANK_AW)
   ) u_bank0 (
      .clk_i   (i_Clock),
      .we_i    (we0),
      .waddr_i (bank_waddr),
      .wdata_i (wr_data),
      .raddr_i (bank_raddr),
      .rdata_o (rdata0)
   );

   fb_bank #(
      .BITS_PER_PIXEL    (BITS_PER_PIXEL),
      .FRAMEBUFFER_DEPTH (FRAMEBUFFER_DEPTH),
      .ADDR_WIDTH        (BANK_AW)
   ) u_bank1 (
      .clk_i   (i_Clock),
      .we_i    (we1),
      .waddr_i (bank_waddr),
      .wdata_i (wr_data),
      .raddr_i (bank_raddr),
      .rdata_o (rdata1)
   );

   // ---------------- outputs ----------------
   // The bank RAMs have no reset; the reset-cleared valid flag forces 0 out
   // of reset and for out-of-range addresses.
   assign o_Read_Data    = rd_valid_q ? (rd_bank_q ? rdata1 : rdata0) : '0;
   assign o_Write_Ready  = !clearing;
   assign o_Clear_Busy   = clearing;
   assign o_Front_Bank   = front_q;
   assign o_Swap_Pending = (state_q == PENDING) || req_q;
   assign o_Swap_Done    = done_q;

endmodule

// File: tb/tb_framebuffer_swap_controller.sv
module tb_framebuffer_swap_controller;

   logic       clk;
   logic       rst_n;
   logic       we;
   logic [4:0] waddr;
   logic [2:0] wdata;
   logic       wready;
   logic [4:0] raddr;
   logic [2:0] rdata;
   logic       vblank;
   logic       req;
   logic       clr_on;
   logic [2:0] clr_color;
   logic       front;
   logic       pending;
   logic       busy;
   logic       done;

   int vectors;
   int miscompares;

   framebuffer_swap_controller #(
      .BITS_PER_PIXEL (3),
      .RESOLUTION_W   (4),
      .RESOLUTION_H   (4),
      .ADDR_WIDTH     (5)
   ) dut (
      .i_Clock         (clk),
      .i_Reset_N       (rst_n),
      .i_Write_Enable  (we),
      .i_Write_Addr    (waddr),
      .i_Write_Data    (wdata),
      .o_Write_Ready   (wready),
      .i_Read_Addr     (raddr),
      .o_Read_Data     (rdata),
      .i_Vblank_Start  (vblank),
      .i_Swap_Request  (req),
      .i_Clear_On_Swap (clr_on),
      .i_Clear_Color   (clr_color),
      .o_Front_Bank    (front),
      .o_Swap_Pending  (pending),
      .o_Clear_Busy    (busy),
      .o_Swap_Done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs until the clear ends, optionally issuing writes to addr 0 each cycle.
   task automatic run_clear(input logic with_writes, output int n_busy, output int n_rdy_low);
      n_busy = 0;
      n_rdy_low = 0;
      while (busy === 1'b1 && n_busy < 200) begin
         n_busy++;
         if (wready === 1'b0) n_rdy_low++;
         if (with_writes) begin
            we = 1'b1; waddr = 5'd0; wdata = 3'b111;
         end
         tick();
      end
      we = 1'b0;
   endtask

   task automatic swap_now();
      req = 1'b1; tick(); req = 1'b0;
      vblank = 1'b1; tick(); vblank = 1'b0;
   endtask

   task automatic init_banks();
      int nb, nr;
      clr_on = 1'b1; clr_color = 3'b000;
      swap_now();
      clr_on = 1'b0;
      run_clear(1'b0, nb, nr);
      vectors++;
      if (nb !== 16) begin miscompares++; $display("FAIL init_clear0_len got %0d exp %0d", nb, 16); end
      clr_on = 1'b1;
      swap_now();
      clr_on = 1'b0;
      run_clear(1'b0, nb, nr);
      vectors++;
      if (nb !== 16) begin miscompares++; $display("FAIL init_clear1_len got %0d exp %0d", nb, 16); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      vectors++; if (front   !== 1'b0)   begin miscompares++; $display("FAIL reset_front got %b exp 0", front); end
      vectors++; if (rdata   !== 3'b000) begin miscompares++; $display("FAIL reset_rdata got %b exp 000", rdata); end
      vectors++; if (pending !== 1'b0)   begin miscompares++; $display("FAIL reset_pending got %b exp 0", pending); end
      vectors++; if (busy    !== 1'b0)   begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
      vectors++; if (done    !== 1'b0)   begin miscompares++; $display("FAIL reset_done got %b exp 0", done); end
      vectors++; if (wready  !== 1'b1)   begin miscompares++; $display("FAIL reset_wready got %b exp 1", wready); end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_swap();
      we = 1'b1; waddr = 5'd5; wdata = 3'b101; tick(); we = 1'b0;
      raddr = 5'd5; tick();
      vectors++; if (rdata !== 3'b000) begin miscompares++; $display("FAIL basic_read_back got %b exp 000", rdata); end
      req = 1'b1; tick(); req = 1'b0;
      vectors++; if (pending !== 1'b1) begin miscompares++; $display("FAIL basic_pending got %b exp 1", pending); end
      vectors++; if (front !== 1'b0) begin miscompares++; $display("FAIL basic_front_pre got %b exp 0", front); end
      vblank = 1'b1; tick(); vblank = 1'b0;
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL basic_done got %b exp 1", done); end
      vectors++; if (front !== 1'b1) begin miscompares++; $display("FAIL basic_front got %b exp 1", front); end
      tick();
      vectors++; if (rdata !== 3'b101) begin miscompares++; $display("FAIL basic_read_front got %b exp 101", rdata); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_low got %b exp 0", done); end
      vectors++; if (pending !== 1'b0) begin miscompares++; $display("FAIL basic_pending_low got %b exp 0", pending); end
   endtask

   task automatic test_long_pending();
      req = 1'b1; tick(); req = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (i == 10) begin we = 1'b1; waddr = 5'd2; wdata = 3'b110; end
         tick();
         we = 1'b0;
         vectors++; if (pending !== 1'b1) begin miscompares++; $display("FAIL long_pending cyc %0d got %b exp 1", i, pending); end
         vectors++; if (front !== 1'b1) begin miscompares++; $display("FAIL long_front cyc %0d got %b exp 1", i, front); end
         vectors++; if (wready !== 1'b1) begin miscompares++; $display("FAIL long_wready cyc %0d got %b exp 1", i, wready); end
      end
      vblank = 1'b1; tick(); vblank = 1'b0;
      vectors++; if (front !== 1'b0) begin miscompares++; $display("FAIL long_commit_front got %b exp 0", front); end
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL long_commit_done got %b exp 1", done); end
      raddr = 5'd2; tick();
      vectors++; if (rdata !== 3'b110) begin miscompares++; $display("FAIL long_read got %b exp 110", rdata); end
   endtask

   task automatic test_clear();
      int nb, nr;
      clr_on = 1'b1; clr_color = 3'b010;
      swap_now();
      clr_on = 1'b0; clr_color = 3'b000;
      vectors++; if (front !== 1'b1) begin miscompares++; $display("FAIL clear_front got %b exp 1", front); end
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL clear_done got %b exp 1", done); end
      run_clear(1'b1, nb, nr);
      vectors++; if (nb !== 16) begin miscompares++; $display("FAIL clear_busy_len got %0d exp %0d", nb, 16); end
      vectors++; if (nr !== 16) begin miscompares++; $display("FAIL clear_rdy_low_len got %0d exp %0d", nr, 16); end
      vectors++; if (wready !== 1'b1) begin miscompares++; $display("FAIL clear_wready_after got %b exp 1", wready); end
      vectors++; if (pending !== 1'b0) begin miscompares++; $display("FAIL clear_pending_after got %b exp 0", pending); end
      swap_now();
      vectors++; if (front !== 1'b0) begin miscompares++; $display("FAIL clear_swap_front got %b exp 0", front); end
      for (int a = 0; a < 16; a++) begin
         raddr = 5'(a); tick();
         vectors++; if (rdata !== 3'b010) begin miscompares++; $display("FAIL clear_pixel addr %0d got %b exp 010", a, rdata); end
      end
   endtask

   task automatic test_same_cycle();
      req = 1'b1; vblank = 1'b1; tick(); req = 1'b0; vblank = 1'b0;
      vectors++; if (pending !== 1'b1) begin miscompares++; $display("FAIL same_pending got %b exp 1", pending); end
      vectors++; if (front !== 1'b0) begin miscompares++; $display("FAIL same_front got %b exp 0", front); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL same_done got %b exp 0", done); end
      tick(); tick(); tick();
      vectors++; if (front !== 1'b0) begin miscompares++; $display("FAIL same_front_wait got %b exp 0", front); end
      vblank = 1'b1; tick(); vblank = 1'b0;
      vectors++; if (front !== 1'b1) begin miscompares++; $display("FAIL same_commit_front got %b exp 1", front); end
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL same_commit_done got %b exp 1", done); end
      vectors++; if (pending !== 1'b0) begin miscompares++; $display("FAIL same_commit_pending got %b exp 0", pending); end
      raddr = 5'd5; tick();
      vectors++; if (rdata !== 3'b101) begin miscompares++; $display("FAIL same_read got %b exp 101", rdata); end
   endtask

   task automatic test_req_during_clear();
      int nb, nr;
      clr_on = 1'b1; clr_color = 3'b011;
      swap_now();
      clr_on = 1'b0; clr_color = 3'b000;
      vectors++; if (front !== 1'b0) begin miscompares++; $display("FAIL rdc_front got %b exp 0", front); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rdc_busy got %b exp 1", busy); end
      tick(); tick();
      req = 1'b1; tick(); req = 1'b0;
      vectors++; if (pending !== 1'b1) begin miscompares++; $display("FAIL rdc_pending got %b exp 1", pending); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rdc_busy_mid got %b exp 1", busy); end
      tick(); tick();
      vblank = 1'b1; tick(); vblank = 1'b0;
      vectors++; if (front !== 1'b0) begin miscompares++; $display("FAIL rdc_no_swap_front got %b exp 0", front); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rdc_no_swap_done got %b exp 0", done); end
      run_clear(1'b0, nb, nr);
      vectors++; if (nb !== 10) begin miscompares++; $display("FAIL rdc_busy_rest got %0d exp %0d", nb, 10); end
      vectors++; if (pending !== 1'b1) begin miscompares++; $display("FAIL rdc_pending_after got %b exp 1", pending); end
      vectors++; if (front !== 1'b0) begin miscompares++; $display("FAIL rdc_front_after got %b exp 0", front); end
      vblank = 1'b1; tick(); vblank = 1'b0;
      vectors++; if (front !== 1'b1) begin miscompares++; $display("FAIL rdc_commit_front got %b exp 1", front); end
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL rdc_commit_done got %b exp 1", done); end
      raddr = 5'd5; tick();
      vectors++; if (rdata !== 3'b011) begin miscompares++; $display("FAIL rdc_read got %b exp 011", rdata); end
   endtask

   task automatic test_reset_mid_clear();
      swap_now();
      vectors++; if (front !== 1'b0) begin miscompares++; $display("FAIL rmc_pre_front got %b exp 0", front); end
      clr_on = 1'b1; clr_color = 3'b101;
      swap_now();
      clr_on = 1'b0; clr_color = 3'b000;
      for (int i = 0; i < 6; i++) tick();
      vectors++; if (front !== 1'b1) begin miscompares++; $display("FAIL rmc_front_mid got %b exp 1", front); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rmc_busy_mid got %b exp 1", busy); end
      #3 rst_n = 1'b0;
      #1;
      vectors++; if (front !== 1'b0) begin miscompares++; $display("FAIL rmc_front got %b exp 0", front); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmc_busy got %b exp 0", busy); end
      vectors++; if (wready !== 1'b1) begin miscompares++; $display("FAIL rmc_wready got %b exp 1", wready); end
      vectors++; if (pending !== 1'b0) begin miscompares++; $display("FAIL rmc_pending got %b exp 0", pending); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rmc_done got %b exp 0", done); end
      vectors++; if (rdata !== 3'b000) begin miscompares++; $display("FAIL rmc_rdata got %b exp 000", rdata); end
      #2 rst_n = 1'b1;
      tick();
      we = 1'b1; waddr = 5'd16; wdata = 3'b111; tick(); we = 1'b0;
      raddr = 5'd16; tick();
      vectors++; if (rdata !== 3'b000) begin miscompares++; $display("FAIL rmc_read16 got %b exp 000", rdata); end
      swap_now();
      vectors++; if (front !== 1'b1) begin miscompares++; $display("FAIL rmc_swap_front got %b exp 1", front); end
      raddr = 5'd0; tick();
      vectors++; if (rdata !== 3'b011) begin miscompares++; $display("FAIL rmc_addr0_intact got %b exp 011", rdata); end
      raddr = 5'd16; tick();
      vectors++; if (rdata !== 3'b000) begin miscompares++; $display("FAIL rmc_read16_front got %b exp 000", rdata); end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
      vblank = 1'b0; req = 1'b0; clr_on = 1'b0; clr_color = '0;
      #12 rst_n = 1'b1;
      tick();
      init_banks();
      test_reset();
      test_basic_swap();
      test_long_pending();
      test_clear();
      test_same_cycle();
      test_req_during_clear();
      test_reset_mid_clear();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
